// File: rtl/bram_port_arbiter_if.sv
// Requester, clear-control and BRAM pin bundle for bram_port_arbiter.
// The arbiter takes the slave side; requesters and the BRAM sit on the master side.
interface bram_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_rvalid;
  logic [DATA_WIDTH-1:0] rd_rdata;

  logic                  clr_start;
  logic                  clr_busy;
  logic                  clr_done;

  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  rd_valid, rd_addr,
    output rd_ready, rd_rvalid, rd_rdata,
    input  clr_start,
    output clr_busy, clr_done,
    output bram_we, bram_addr, bram_din,
    input  bram_dout
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output rd_valid, rd_addr,
    input  rd_ready, rd_rvalid, rd_rdata,
    output clr_start,
    input  clr_busy, clr_done,
    input  bram_we, bram_addr, bram_din,
    output bram_dout
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin write/read arbiter in front of a single-port BRAM, with a
// clear sequencer that fills the memory with CLEAR_VALUE.
module bram_port_arbiter #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input logic               clk,
  input logic               rst,
  bram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN
  } state_e;

  typedef enum logic {
    SIDE_WR,
    SIDE_RD
  } side_e;

  state_e                state_q,     state_d;
  side_e                 rr_last_q,   rr_last_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q,  clr_addr_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic                  rd_rvalid_q, rd_rvalid_d;
  logic                  clr_done_q,  clr_done_d;

  logic wr_grant;
  logic rd_grant;
  logic sweep_last;

  assign sweep_last = (clr_addr_q == '1);

  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (state_q == ST_RUN) begin
      if (bus.wr_valid && bus.rd_valid) begin
        if (rr_last_q == SIDE_RD) begin
          wr_grant = 1'b1;
        end else begin
          rd_grant = 1'b1;
        end
      end else begin
        wr_grant = bus.wr_valid;
        rd_grant = bus.rd_valid;
      end
    end
  end

  // Address is held from the previous cycle when nothing is granted, so the
  // BRAM keeps presenting the last location on dout.
  always_comb begin
    bus.bram_we   = 1'b0;
    bus.bram_addr = addr_hold_q;
    bus.bram_din  = bus.wr_data;
    if (state_q == ST_CLEAR) begin
      bus.bram_we   = 1'b1;
      bus.bram_addr = clr_addr_q;
      bus.bram_din  = CLEAR_VALUE;
    end else if (wr_grant) begin
      bus.bram_we   = 1'b1;
      bus.bram_addr = bus.wr_addr;
    end else if (rd_grant) begin
      bus.bram_addr = bus.rd_addr;
    end
  end

  assign bus.wr_ready  = wr_grant;
  assign bus.rd_ready  = rd_grant;
  assign bus.rd_rvalid = rd_rvalid_q;
  assign bus.rd_rdata  = bus.bram_dout;
  assign bus.clr_busy  = (state_q == ST_CLEAR);
  assign bus.clr_done  = clr_done_q;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    clr_addr_d  = clr_addr_q;
    addr_hold_d = bus.bram_addr;
    rd_rvalid_d = rd_grant;
    clr_done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (sweep_last) begin
          clr_done_d = 1'b1;
          clr_addr_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wr_grant) begin
          rr_last_d = SIDE_WR;
        end else if (rd_grant) begin
          rr_last_d = SIDE_RD;
        end
        if (bus.clr_start) begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= SIDE_RD;
      clr_addr_q  <= '0;
      addr_hold_q <= '0;
      rd_rvalid_q <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      clr_addr_q  <= clr_addr_d;
      addr_hold_q <= addr_hold_d;
      rd_rvalid_q <= rd_rvalid_d;
      clr_done_q  <= clr_done_d;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: a 16-word BRAM model, a
// shadow-memory reference for grants and read returns, vectors and sequences.
module tb_bram_port_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [DW-1:0] CV  = 32'h0000_00A5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_port_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .CLEAR_ON_RESET(1'b1),
    .CLEAR_VALUE   (CV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] bram_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.bram_we) bram_mem[bus.bram_addr] <= bus.bram_din;
    bus.bram_dout <= bram_mem[bus.bram_addr];
  end

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  bit            run_mode;
  bit            last_was_wr;
  bit            pend_valid;
  logic [DW-1:0] pend_data;
  logic [AW-1:0] last_addr;
  logic          gw, gr;

  typedef struct {
    logic wv;
    logic rv;
    logic ew;
    logic er;
  } arb_vec_t;
  arb_vec_t vecs [14];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, then check everything that is
  // visible for that cycle against the reference.
  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rv, input logic [AW-1:0] ra, input logic cs,
                      output logic got_w, output logic got_r);
    logic exp_w, exp_r;
    @(negedge clk);
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_valid  = rv;
    bus.rd_addr   = ra;
    bus.clr_start = cs;
    #1;
    check_bit("rd_rvalid", bus.rd_rvalid, pend_valid);
    if (pend_valid) check("rd_rdata", bus.rd_rdata, pend_data);
    exp_w = run_mode && wv && (!rv || !last_was_wr);
    exp_r = run_mode && rv && (!wv || last_was_wr);
    check_bit("wr_ready", bus.wr_ready, exp_w);
    check_bit("rd_ready", bus.rd_ready, exp_r);
    check_bit("single_grant", bus.wr_ready & bus.rd_ready, 1'b0);
    got_w = bus.wr_ready;
    got_r = bus.rd_ready;
    pend_valid = exp_r;
    if (exp_w) begin
      check_bit("bram_we_wr", bus.bram_we, 1'b1);
      check("bram_addr_wr", DW'(bus.bram_addr), DW'(wa));
      check("bram_din_wr", bus.bram_din, wd);
      ref_mem[wa] = wd;
      last_was_wr = 1'b1;
      last_addr   = wa;
    end else if (exp_r) begin
      check_bit("bram_we_rd", bus.bram_we, 1'b0);
      check("bram_addr_rd", DW'(bus.bram_addr), DW'(ra));
      pend_data   = ref_mem[ra];
      last_was_wr = 1'b0;
      last_addr   = ra;
    end else if (run_mode) begin
      check_bit("bram_we_idle", bus.bram_we, 1'b0);
      check("bram_addr_hold", DW'(bus.bram_addr), DW'(last_addr));
    end
    if (run_mode && cs) run_mode = 1'b0;
  endtask

  task automatic idle_step();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, gw, gr);
  endtask

  // Full sweep starting this coming cycle; returns early after the cycle that
  // writes address abort_at so the caller can assert reset mid-sweep.
  task automatic sweep_check(input int abort_at);
    for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = CV;
    for (int i = 0; i < int'(DEPTH); i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
           1'($urandom_range(0, 1)), AW'($urandom), (i == 5), gw, gr);
      check_bit("clr_busy", bus.clr_busy, 1'b1);
      check_bit("clr_we", bus.bram_we, 1'b1);
      check("clr_addr", DW'(bus.bram_addr), DW'(i));
      check("clr_din", bus.bram_din, CV);
      check_bit("clr_done_early", bus.clr_done, 1'b0);
      if (i == abort_at) return;
    end
    run_mode  = 1'b1;
    last_addr = '1;
    idle_step();
    check_bit("clr_done_pulse", bus.clr_done, 1'b1);
    check_bit("clr_busy_end", bus.clr_busy, 1'b0);
    idle_step();
    check_bit("clr_done_single", bus.clr_done, 1'b0);
  endtask

  // Asserts rst now (so it is sampled at the coming edge), holds it for the
  // given number of edges, then releases it and checks the IDLE cycle.
  task automatic do_reset(input int cycles);
    rst           = 1'b1;
    bus.wr_valid  = 1'b1;
    bus.rd_valid  = 1'b1;
    bus.clr_start = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      #1;
      check_bit("rst_rvalid", bus.rd_rvalid, 1'b0);
      check_bit("rst_busy", bus.clr_busy, 1'b0);
      check_bit("rst_done", bus.clr_done, 1'b0);
      check_bit("rst_wr_ready", bus.wr_ready, 1'b0);
      check_bit("rst_rd_ready", bus.rd_ready, 1'b0);
      check_bit("rst_we", bus.bram_we, 1'b0);
    end
    rst = 1'b0;
    #1;
    check_bit("idle_busy", bus.clr_busy, 1'b0);
    check_bit("idle_wr_ready", bus.wr_ready, 1'b0);
    check_bit("idle_rd_ready", bus.rd_ready, 1'b0);
    check_bit("idle_we", bus.bram_we, 1'b0);
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    run_mode     = 1'b0;
    pend_valid   = 1'b0;
    last_was_wr  = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst           = 1'b1;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_valid  = 1'b0;
    bus.rd_addr   = '0;
    bus.clr_start = 1'b0;
    last_addr     = '0;
    pend_data     = '0;

    // Power-on reset, IDLE, then the automatic sweep.
    do_reset(2);
    sweep_check(-1);

    for (int i = 0; i < int'(DEPTH); i++) step(1'b0, '0, '0, 1'b1, AW'(i), 1'b0, gw, gr);
    idle_step();
    check("last_clear_read", bus.rd_rdata, CV);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].wv, AW'(i), 32'hC000_0000 + DW'(i), vecs[i].rv, AW'(i + 3), 1'b0, gw, gr);
      check_bit($sformatf("vec%0d_wr", i), gw, vecs[i].ew);
      check_bit($sformatf("vec%0d_rd", i), gr, vecs[i].er);
    end
    idle_step();

    // Write then read the same address in the next cycle.
    step(1'b1, 4'd3, 32'h1234_5678, 1'b0, '0, 1'b0, gw, gr);
    step(1'b0, '0, '0, 1'b1, 4'd3, 1'b0, gw, gr);
    check_bit("raw_rd_ready", gr, 1'b1);
    idle_step();
    check_bit("raw_rvalid", bus.rd_rvalid, 1'b1);
    check("raw_rdata", bus.rd_rdata, 32'h1234_5678);

    // Back-to-back reads of addresses 0..3.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, AW'(i), 1'b0, gw, gr);
      check_bit("b2b_rd_ready", gr, 1'b1);
    end
    idle_step();

    // Randomised traffic with occasional clear commands.
    for (int n = 0; n < 400; n++) begin
      logic cs;
      cs = ($urandom_range(0, 59) == 0);
      step(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
           1'($urandom_range(0, 1)), AW'($urandom), cs, gw, gr);
      if (cs) sweep_check(-1);
    end

    // Read granted in the same cycle as clr_start.
    step(1'b0, '0, '0, 1'b1, 4'd5, 1'b1, gw, gr);
    check_bit("clr_cycle_rd_ready", gr, 1'b1);
    sweep_check(-1);

    // Reset with a read in flight, then reset again at sweep address 7.
    step(1'b1, 4'd2, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, gw, gr);
    step(1'b0, '0, '0, 1'b1, 4'd2, 1'b0, gw, gr);
    check_bit("pre_rst_rd_ready", gr, 1'b1);
    do_reset(2);
    sweep_check(7);
    do_reset(2);
    sweep_check(-1);

    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, AW'(4 * i + 1), 1'b0, gw, gr);
    idle_step();
    check("final_clear_read", bus.rd_rdata, CV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Arbitrates a single-port synchronous BRAM between two requesters:
  - a write requester (frame/feature writer)
  - a read requester (detection engine)
- Round-robin arbitration over valid/ready handshakes.
- Returns read data with fixed latency.
- Owns a clear sequencer that fills memory with a constant after reset or on command.
- Sits directly in front of the BRAM and drives its we/addr/din pins combinationally.

Parameters:
DATA_WIDTH, 32, BRAM word width
ADDR_WIDTH, 16, BRAM address width; DEPTH = 2**ADDR_WIDTH
CLEAR_ON_RESET, 1, 1 = run a full clear sweep automatically after reset deasserts
CLEAR_VALUE, 0, word written to every address during a clear sweep

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted this cycle
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
rd_valid  in  1  read request
rd_ready  out  1  read accepted this cycle
rd_addr  in  ADDR_WIDTH  read address
rd_rvalid  out  1  read data valid (1-cycle pulse per accepted read)
rd_rdata  out  DATA_WIDTH  read data
clr_start  in  1  request a clear sweep (pulse)
clr_busy  out  1  clear sweep in progress
clr_done  out  1  1-cycle pulse when a sweep finishes
bram_we  out  1  to BRAM we
bram_addr  out  ADDR_WIDTH  to BRAM addr
bram_din  out  DATA_WIDTH  to BRAM din
bram_dout  in  DATA_WIDTH  from BRAM dout (registered in BRAM, 1-cycle read)

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - While rst is high: state=IDLE, wr_ready=0, rd_ready=0, bram_we=0, rd_rvalid=0, clr_busy=0, clr_done=0, clr_addr=0, rr_last=RD.
  - rst is sampled only at posedge clk.
- FSM states:
  - IDLE: one cycle after reset. Goes to CLEAR if CLEAR_ON_RESET=1, else to RUN.
  - CLEAR:
    - Each cycle: bram_we=1, bram_addr=clr_addr, bram_din=CLEAR_VALUE; clr_addr increments.
    - After writing DEPTH-1: clr_done=1 for one cycle, clr_addr returns to 0, state goes to RUN.
    - clr_busy=1 throughout; both readies are 0.
    - A sweep takes exactly DEPTH cycles.
  - RUN: arbitration active. clr_start=1 goes to CLEAR next cycle; the arbiter still grants in that same cycle.
- Arbitration (RUN only; combinational grant):
  - Only wr_valid: wr_ready=1.
  - Only rd_valid: rd_ready=1.
  - Both valid: grant the side not equal to rr_last.
  - rr_last updates to the granted side on every grant.
  - Never grant both in one cycle.
  - Starvation bound: a continuously valid requester waits at most 1 cycle.
- BRAM drive:
  - Write grant: bram_we=1, bram_addr=wr_addr, bram_din=wr_data.
  - Read grant: bram_we=0, bram_addr=rd_addr.
  - No grant: bram_we=0; bram_addr holds its last value; bram_din is don't-care.
- Read return:
  - rd_rvalid is registered. It is high in cycle N+1 exactly when a read was granted in cycle N.
  - rd_rdata = bram_dout, passed combinationally in cycle N+1.
  - Back-to-back reads give back-to-back rd_rvalid.
  - A read granted in the cycle clr_start is seen still returns rd_rvalid in the following cycle.
- Ordering: a write granted in cycle N followed by a read to the same address in cycle N+1 or later returns the new data.
- Boundary cases:
  - clr_start while in CLEAR or IDLE: ignored.
  - clr_addr wraps only at sweep end.
  - Reset mid-sweep: abort, no clr_done. The post-reset sweep restarts from address 0 if CLEAR_ON_RESET=1.
  - Reset drops any pending rd_rvalid.

Test Plan:
- Reset, ADDR_WIDTH=4, CLEAR_ON_RESET=1, CLEAR_VALUE=0xA5 → CLEAR entered 1 cycle after reset; 16 writes to addresses 0..15; clr_done pulses once; then read every address → all return 0xA5.
- RUN: write addr 3 = 0x1234_5678, then read addr 3 in the next cycle → rd_rvalid one cycle after rd_ready, rd_rdata=0x12345678.
- wr_valid and rd_valid held high for 6 cycles from reset state → grants alternate WR,RD,WR,RD,WR,RD; each rd_ready is followed by rd_rvalid; never both readies high.
- Only rd_valid held high for 4 cycles (addresses 0..3) → 4 consecutive rd_ready, followed by 4 consecutive rd_rvalid with the matching data.
- clr_start pulsed in RUN with a read granted the same cycle → that read's rd_rvalid still appears; next cycle clr_busy=1 and readies are 0 for 16 cycles; clr_start pulsed again mid-sweep is ignored.
- rst asserted at sweep address 7 → clr_done never pulses; after release the sweep restarts at address 0 and completes in 16 cycles.
